// File: rtl/phy_hard_reset_tx.sv
// ---------------------------------------------------------------------------
// phy_hard_reset_tx
//   PHY-side transmitter for USB-PD Hard Reset / Cable Reset signalling.
//   Accepts a TRANSMIT request, waits for the CC line to go idle, then
//   serialises the 64-bit preamble followed by the 20-bit reset ordered set
//   towards the BMC encoder. Success is reported by a one-cycle PHY_Reset
//   pulse; expiry of tHardResetComplete is reported by a one-cycle tx_fail.
//
// Ports
//   CLK        in   clock, rising edge
//   reset      in   asynchronous active-high reset
//   TRANSMIT   in   request code (0101 Hard Reset, 0110 Cable Reset)
//   tx_req     in   request strobe, TRANSMIT sampled while high
//   cc_busy    in   1 = CC line not idle
//   bit_ready  in   BMC encoder accepts bit_out this cycle
//   bit_out    out  serial data bit
//   bit_valid  out  bit_out valid
//   busy       out  request in progress
//   PHY_Reset  out  one-cycle pulse on successful transmission
//   tx_fail    out  one-cycle pulse on timeout
// ---------------------------------------------------------------------------
module phy_hard_reset_tx #(
    parameter int unsigned HR_COMPLETE_CYCLES = 60000
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic [3:0] TRANSMIT,
    input  logic       tx_req,
    input  logic       cc_busy,
    input  logic       bit_ready,
    output logic       bit_out,
    output logic       bit_valid,
    output logic       busy,
    output logic       PHY_Reset,
    output logic       tx_fail
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_IDLE = 3'd1;
    localparam logic [2:0] S_PREAMBLE  = 3'd2;
    localparam logic [2:0] S_ORDSET    = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;
    localparam logic [2:0] S_FAIL      = 3'd5;

    localparam logic [3:0] CODE_HARD  = 4'b0101;
    localparam logic [3:0] CODE_CABLE = 4'b0110;

    localparam logic [4:0] SYM_RST1  = 5'b00111;
    localparam logic [4:0] SYM_RST2  = 5'b11001;
    localparam logic [4:0] SYM_SYNC1 = 5'b11000;
    localparam logic [4:0] SYM_SYNC3 = 5'b00110;

    // Ordered sets packed so that index j is the j-th bit on the wire:
    // first symbol in the low bits, each symbol LSB first.
    localparam logic [19:0] ORD_HARD  = {SYM_RST2, SYM_RST1, SYM_RST1, SYM_RST1};
    localparam logic [19:0] ORD_CABLE = {SYM_SYNC3, SYM_RST1, SYM_SYNC1, SYM_RST1};

    localparam logic [16:0] TIMER_LIMIT = 17'(HR_COMPLETE_CYCLES);

    logic [2:0]  r_state;
    logic        r_cable;
    logic [5:0]  r_cnt;
    logic [15:0] r_timer;
    logic        r_bit_out;
    logic        r_bit_valid;
    logic        r_busy;
    logic        r_phy_reset;
    logic        r_tx_fail;

    logic [2:0]  w_state_nxt;
    logic        w_cable_nxt;
    logic [5:0]  w_cnt_nxt;
    logic [5:0]  w_cnt_inc;
    logic [15:0] w_timer_nxt;
    logic [16:0] w_timer_inc;
    logic        w_bit_nxt;
    logic        w_valid_nxt;
    logic        w_xfer;
    logic        w_expire;
    logic [19:0] w_ordset;

    always_comb begin
        w_ordset    = r_cable ? ORD_CABLE : ORD_HARD;
        w_xfer      = r_bit_valid & bit_ready;
        w_cnt_inc   = r_cnt + 6'd1;
        // Expiry is flagged in the cycle whose count would reach the limit,
        // so the FAIL transition lands on the following edge.
        w_timer_inc = {1'b0, r_timer} + 17'd1;
        w_expire    = (w_timer_inc == TIMER_LIMIT);

        w_state_nxt = r_state;
        w_cable_nxt = r_cable;
        w_cnt_nxt   = r_cnt;
        w_timer_nxt = r_timer;
        w_bit_nxt   = r_bit_out;

        case (r_state)
            S_IDLE: begin
                if (tx_req && (TRANSMIT == CODE_HARD || TRANSMIT == CODE_CABLE)) begin
                    w_cable_nxt = (TRANSMIT == CODE_CABLE);
                    w_timer_nxt = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                w_timer_nxt = w_timer_inc[15:0];
                if (w_expire) begin
                    w_state_nxt = S_FAIL;
                end else if (!cc_busy) begin
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = 1'b0;
                    w_state_nxt = S_PREAMBLE;
                end
            end
            S_PREAMBLE: begin
                w_timer_nxt = w_timer_inc[15:0];
                if (w_expire) begin
                    w_state_nxt = S_FAIL;
                end else if (w_xfer) begin
                    if (r_cnt == 6'd63) begin
                        w_cnt_nxt   = '0;
                        w_bit_nxt   = w_ordset[0];
                        w_state_nxt = S_ORDSET;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                        // Preamble bit i equals i[0]; the next one is the inverse of cnt[0].
                        w_bit_nxt = ~r_cnt[0];
                    end
                end
            end
            S_ORDSET: begin
                w_timer_nxt = w_timer_inc[15:0];
                // Final bit transferring in the expiry cycle still counts as success.
                if (w_xfer && r_cnt == 6'd19) begin
                    w_state_nxt = S_DONE;
                end else if (w_expire) begin
                    w_state_nxt = S_FAIL;
                end else if (w_xfer) begin
                    w_cnt_nxt = w_cnt_inc;
                    w_bit_nxt = w_ordset[w_cnt_inc[4:0]];
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_FAIL:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        w_valid_nxt = (w_state_nxt == S_PREAMBLE) || (w_state_nxt == S_ORDSET);
        if (!w_valid_nxt) begin
            w_bit_nxt = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cable     <= 1'b0;
            r_cnt       <= '0;
            r_timer     <= '0;
            r_bit_out   <= 1'b0;
            r_bit_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_phy_reset <= 1'b0;
            r_tx_fail   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cable     <= w_cable_nxt;
            r_cnt       <= w_cnt_nxt;
            r_timer     <= w_timer_nxt;
            r_bit_out   <= w_bit_nxt;
            r_bit_valid <= w_valid_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_phy_reset <= (w_state_nxt == S_DONE);
            r_tx_fail   <= (w_state_nxt == S_FAIL);
        end
    end

    assign bit_out   = r_bit_out;
    assign bit_valid = r_bit_valid;
    assign busy      = r_busy;
    assign PHY_Reset = r_phy_reset;
    assign tx_fail   = r_tx_fail;

endmodule

// File: tb/tb_phy_hard_reset_tx.sv
// ---------------------------------------------------------------------------
// tb_phy_hard_reset_tx
//   Scoreboard bench for phy_hard_reset_tx with tHardResetComplete = 100.
//   Each request is modelled up front (bits that will be accepted, outcome
//   and its cycle); a monitor pops and compares as the DUT presents them.
// ---------------------------------------------------------------------------
module tb_phy_hard_reset_tx;

    localparam int unsigned HR    = 100;
    localparam int unsigned NBITS = 84;

    logic       CLK = 1'b0;
    logic       reset;
    logic [3:0] TRANSMIT;
    logic       tx_req;
    logic       cc_busy;
    logic       bit_ready;
    logic       bit_out;
    logic       bit_valid;
    logic       busy;
    logic       PHY_Reset;
    logic       tx_fail;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned gcyc   = 0;

    typedef struct {
        bit          is_fail;
        int unsigned cyc;
    } ev_t;

    bit  bitq[$];
    ev_t evq[$];

    phy_hard_reset_tx #(.HR_COMPLETE_CYCLES(HR)) u_dut (
        .CLK       (CLK),
        .reset     (reset),
        .TRANSMIT  (TRANSMIT),
        .tx_req    (tx_req),
        .cc_busy   (cc_busy),
        .bit_ready (bit_ready),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .busy      (busy),
        .PHY_Reset (PHY_Reset),
        .tx_fail   (tx_fail)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) gcyc <= gcyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, gcyc);
        end
    endtask

    // k-th bit on the wire: alternating preamble, then symbols sent LSB first.
    function automatic bit ref_bit(input bit cable, input int unsigned k);
        logic [4:0] rst1, rst2, sync1, sync3, sym;
        int unsigned j;
        rst1 = 5'b00111; rst2 = 5'b11001; sync1 = 5'b11000; sync3 = 5'b00110;
        if (k < 64) return bit'(k % 2);
        j = k - 64;
        case (j / 5)
            0:       sym = rst1;
            1:       sym = cable ? sync1 : rst1;
            2:       sym = rst1;
            default: sym = cable ? sync3 : rst2;
        endcase
        return sym[j % 5];
    endfunction

    // Monitor: compares every accepted bit, every stalled bit and every pulse.
    always @(negedge CLK) begin
        if (!reset) begin
            if (bit_valid && bit_ready) begin
                if (bitq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_bit: got bit %0b, expected none (cycle %0d)", bit_out, gcyc);
                end else begin
                    check("bit", bit_out, bitq.pop_front());
                end
            end else if (bit_valid && bitq.size() > 0) begin
                check("stall_hold", bit_out, bitq[0]);
            end
            if (PHY_Reset || tx_fail) begin
                if (evq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_pulse: got PHY_Reset=%0b tx_fail=%0b, expected none (cycle %0d)",
                             PHY_Reset, tx_fail, gcyc);
                end else begin
                    ev_t ev;
                    ev = evq.pop_front();
                    check("pulse_kind", {PHY_Reset, tx_fail}, ev.is_fail ? 32'd1 : 32'd2);
                    check("pulse_cycle", gcyc, ev.cyc);
                end
            end
        end
    end

    // One request. Must be called at posedge+1; returns at posedge+1 of the
    // first cycle after the outcome pulse (earliest point a new request is legal).
    task automatic run_txn(input logic [3:0] code, input int unsigned w_busy,
                           input int unsigned stall_pct, input int unsigned lead,
                           input int unsigned stall_from, input int unsigned spur,
                           input int unsigned reset_at);
        bit          rdy[512];
        bit          vcode, cable, ok;
        int unsigned start, n, lst, e_cyc, last_v, cend, base;
        ev_t         ev;
        vcode = (code == 4'b0101) || (code == 4'b0110);
        cable = (code == 4'b0110);
        start = w_busy + 2;
        base  = gcyc;
        for (int unsigned c = 0; c < 512; c++) begin
            if (c >= start && c < start + lead)           rdy[c] = 1'b0;
            else if (stall_from != 0 && c >= stall_from)  rdy[c] = 1'b0;
            else if ($urandom_range(99) < stall_pct)      rdy[c] = 1'b0;
            else                                          rdy[c] = 1'b1;
        end
        n = 0; lst = 0; ok = 1'b0;
        for (int unsigned c = start; c <= HR && !ok; c++) begin
            if (rdy[c]) begin
                n++;
                if (n == NBITS) begin ok = 1'b1; lst = c; end
            end
        end
        e_cyc  = ok ? lst + 1 : HR + 1;
        last_v = ok ? lst : HR;
        if (vcode) begin
            for (int unsigned k = 0; k < n; k++) bitq.push_back(ref_bit(cable, k));
            ev.is_fail = !ok;
            ev.cyc     = base + e_cyc;
            evq.push_back(ev);
        end
        cend = vcode ? e_cyc : 5;
        for (int unsigned c = 0; c <= cend; c++) begin
            tx_req    = (c == 0) || (spur != 0 && c == spur);
            TRANSMIT  = (c == 0) ? code : ((code == 4'b0101) ? 4'b0110 : 4'b0101);
            cc_busy   = (c >= 1 && c <= w_busy);
            bit_ready = rdy[c];
            if (reset_at != 0 && c == reset_at) begin
                #3 reset = 1'b1;
                #1;
                check("rst_bit_out", bit_out, 0);
                check("rst_bit_valid", bit_valid, 0);
                check("rst_busy", busy, 0);
                check("rst_phy_reset", PHY_Reset, 0);
                check("rst_tx_fail", tx_fail, 0);
                bitq.delete();
                evq.delete();
                @(posedge CLK); #1;
                reset   = 1'b0;
                tx_req  = 1'b0;
                cc_busy = 1'b0;
                for (int unsigned i = 0; i < 100; i++) begin
                    @(negedge CLK);
                    check("post_rst_busy", busy, 0);
                    check("post_rst_valid", bit_valid, 0);
                    @(posedge CLK); #1;
                end
                return;
            end
            @(negedge CLK);
            check("busy", busy, vcode && c >= 1 && c <= e_cyc);
            check("bit_valid", bit_valid, vcode && c >= start && c <= last_v);
            @(posedge CLK); #1;
        end
        tx_req = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; tx_req = 1'b0; TRANSMIT = 4'b0000; cc_busy = 1'b0; bit_ready = 1'b1;
        #12;
        check("reset_bit_out", bit_out, 0);
        check("reset_bit_valid", bit_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_phy_reset", PHY_Reset, 0);
        check("reset_tx_fail", tx_fail, 0);
        @(posedge CLK); #1;
        reset = 1'b0;
        @(posedge CLK); #1;

        run_txn(4'b0101, 0,    0, 0,  0,  0,  0);  // Hard Reset, minimum latency
        run_txn(4'b0110, 0,    0, 0,  0,  0,  0);  // Cable Reset
        run_txn(4'b0101, 10,   0, 0,  0,  0,  0);  // busy line for 10 cycles
        run_txn(4'b0110, 0,   10, 0,  0,  20, 0);  // backpressure + ignored request
        run_txn(4'b0101, 0,    0, 15, 0,  0,  0);  // last bit on the expiry cycle
        run_txn(4'b0101, 0,    0, 16, 0,  0,  0);  // one stall too many
        run_txn(4'b0101, 1000, 0, 0,  0,  0,  0);  // line never idle
        run_txn(4'b0110, 0,    0, 0,  40, 0,  0);  // stalled mid-preamble until expiry
        run_txn(4'b0000, 0,    0, 0,  0,  0,  0);  // ignored code
        run_txn(4'b0011, 0,    0, 0,  0,  0,  0);  // ignored code
        run_txn(4'b0101, 0,    0, 0,  0,  0,  75); // reset mid-ordered-set
        run_txn(4'b0101, 0,    0, 0,  0,  0,  0);  // normal after reset

        for (int i = 0; i < 12; i++) begin
            logic [3:0]  code;
            int unsigned w, sp;
            code = ($urandom_range(1) == 0) ? 4'b0101 : 4'b0110;
            w    = $urandom_range(4);
            sp   = ($urandom_range(1) == 0) ? 0 : w + 2 + $urandom_range(60);
            run_txn(code, w, $urandom_range(20), 0, 0, sp, 0);
        end

        for (int i = 0; i < 5; i++) begin @(posedge CLK); #1; end
        check("bitq_drained", bitq.size(), 0);
        check("evq_drained", evq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
